sram_responder: RTL and testbench

Memory-side responder for the SLC-3 datapath's active-low SRAM strobe protocol (Mem_CE/OE/WE/UB/LB). It serves the control unit's two-cycle read (fetch, LDR) and two-cycle write (STR) sequences. It uses an on-chip byte-lane word memory plus one memory-mapped I/O word (switches in, hex display out). It sits between MAR/MDR and the board I/O in the top level and replaces the external SRAM for simulation and FPGA builds.

---
 rtl/mem_resp_pkg.sv | 10 +
 rtl/sram_responder_if.sv | 20 ++
 rtl/sp_ram_be.sv | 21 ++
 rtl/sram_responder.sv | 89 ++++++++
 tb/tb_sram_responder.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/mem_resp_pkg.sv
// Shared types and constants for the SLC-3 SRAM-strobe responder.
package mem_resp_pkg;
  localparam int          DATA_W      = 16;
  localparam logic [15:0] IO_ADDR_DEF = 16'hFFFF;

  typedef enum logic [2:0] {IDLE, RD1, RD2, WR1, WR2} state_t;

  // Where the registered read path sources its word from
  typedef enum logic [1:0] {SRC_NONE, SRC_RAM, SRC_IO} rd_src_t;
endpackage

// File: rtl/sram_responder_if.sv
// Active-low SRAM strobe bus between the control unit (master) and the responder.
interface sram_responder_if import mem_resp_pkg::*; #(
  parameter int ADDR_W = 16
);
  logic              Mem_CE, Mem_OE, Mem_WE, Mem_UB, Mem_LB;
  logic [ADDR_W-1:0] ADDR;
  logic [DATA_W-1:0] Data_to_SRAM;
  logic [DATA_W-1:0] Data_from_SRAM;
  logic              Rd_Valid;
  logic              Wr_Ack;

  modport master (
    output Mem_CE, Mem_OE, Mem_WE, Mem_UB, Mem_LB, ADDR, Data_to_SRAM,
    input  Data_from_SRAM, Rd_Valid, Wr_Ack
  );
  modport slave (
    input  Mem_CE, Mem_OE, Mem_WE, Mem_UB, Mem_LB, ADDR, Data_to_SRAM,
    output Data_from_SRAM, Rd_Valid, Wr_Ack
  );
endinterface

// File: rtl/sp_ram_be.sv
// Single-port synchronous RAM, 16-bit words, per-byte write enable, registered read.
module sp_ram_be import mem_resp_pkg::*; #(
  parameter int DEPTH     = 4096,
  parameter int AW        = $clog2(DEPTH),
  parameter     INIT_FILE = ""
) (
  input  logic              Clk,
  input  logic [1:0]        we,
  input  logic              re,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge Clk) begin
    if (we[1]) mem[addr][15:8] <= wdata[15:8];
    if (we[0]) mem[addr][7:0]  <= wdata[7:0];
    if (re)    rdata           <= mem[addr];
  end
endmodule

// File: rtl/sram_responder.sv
// Memory-side responder for the SLC-3 two-cycle read/write strobe protocol:
// on-chip byte-lane RAM plus one memory-mapped I/O word (switches / hex display).
module sram_responder import mem_resp_pkg::*; #(
  parameter int                ADDR_W    = 16,
  parameter int                DEPTH     = 4096,
  parameter logic [ADDR_W-1:0] IO_ADDR   = ADDR_W'(IO_ADDR_DEF),
  parameter                    INIT_FILE = ""
) (
  input  logic              Clk,
  input  logic              Reset,
  sram_responder_if.slave   bus,
  input  logic [DATA_W-1:0] Switches,
  output logic [DATA_W-1:0] HEX_Data
);
  localparam int AW = $clog2(DEPTH);

  state_t            state;
  rd_src_t           rd_src;
  logic [1:0]        rd_lanes;
  logic [DATA_W-1:0] io_q, ram_q, rd_word;
  logic              rd, wr, is_io, in_ram, commit, wr_ack;
  logic [1:0]        lanes, ram_we;

  assign rd     = !bus.Mem_CE && !bus.Mem_OE && bus.Mem_WE;
  assign wr     = !bus.Mem_CE && !bus.Mem_WE;
  assign lanes  = {!bus.Mem_UB, !bus.Mem_LB};
  assign is_io  = (bus.ADDR == IO_ADDR);
  assign in_ram = !is_io && (32'(bus.ADDR) < DEPTH);
  // The single commit edge of a write burst: second WE-low sample
  assign commit = (state == WR1) && wr;
  assign ram_we = (commit && in_ram) ? lanes : 2'b00;

  sp_ram_be #(.DEPTH(DEPTH), .AW(AW), .INIT_FILE(INIT_FILE)) u_ram (
    .Clk   (Clk),
    .we    (ram_we),
    .re    (rd),
    .addr  (bus.ADDR[AW-1:0]),
    .wdata (bus.Data_to_SRAM),
    .rdata (ram_q)
  );

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state    <= IDLE;
      wr_ack   <= 1'b0;
      HEX_Data <= '0;
      rd_src   <= SRC_NONE;
      rd_lanes <= 2'b00;
      io_q     <= '0;
    end else begin
      wr_ack <= commit;
      if (commit && is_io) begin
        if (lanes[1]) HEX_Data[15:8] <= bus.Data_to_SRAM[15:8];
        if (lanes[0]) HEX_Data[7:0]  <= bus.Data_to_SRAM[7:0];
      end
      // Read path registers alongside the RAM address, so every OE-low
      // sample yields data one cycle later
      if (rd) begin
        rd_src   <= is_io ? SRC_IO : (in_ram ? SRC_RAM : SRC_NONE);
        rd_lanes <= lanes;
        io_q     <= Switches;
      end
      case (state)
        IDLE:    state <= wr ? WR1 : (rd ? RD1 : IDLE);
        RD1:     state <= rd ? RD2 : IDLE;
        RD2:     state <= rd ? RD2 : IDLE;
        WR1:     state <= wr ? WR2 : IDLE;
        WR2:     state <= wr ? WR2 : IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    rd_word = '0;
    case (rd_src)
      SRC_RAM: rd_word = ram_q;
      SRC_IO:  rd_word = io_q;
      default: rd_word = '0;
    endcase
    rd_word = rd_word & {{8{rd_lanes[1]}}, {8{rd_lanes[0]}}};
  end

  // Valid combinationally in the second OE-low cycle so LD_MDR captures it
  // at that cycle's closing edge; an OE that has already risen aborts.
  assign bus.Rd_Valid       = rd && ((state == RD1) || (state == RD2));
  assign bus.Data_from_SRAM = bus.Rd_Valid ? rd_word : '0;
  assign bus.Wr_Ack         = wr_ack;
endmodule

// File: tb/tb_sram_responder.sv
// Directed self-checking bench for sram_responder.
module tb_sram_responder;
  import mem_resp_pkg::*;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [15:0] Switches, HEX_Data;
  int          n_cmp = 0, n_err = 0;
  int          ack_cnt = 0, vld_cnt = 0;

  sram_responder_if #(.ADDR_W(16)) bus ();

  sram_responder #(.ADDR_W(16), .DEPTH(4096), .IO_ADDR(16'hFFFF), .INIT_FILE("")) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .bus      (bus),
    .Switches (Switches),
    .HEX_Data (HEX_Data)
  );

  always #5 Clk = ~Clk;

  // Mid-cycle observation of the pulse outputs
  always @(negedge Clk) begin
    if (bus.Wr_Ack)   ack_cnt++;
    if (bus.Rd_Valid) vld_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic idle_bus;
    bus.Mem_CE = 1'b1; bus.Mem_OE = 1'b1; bus.Mem_WE = 1'b1;
    bus.Mem_UB = 1'b0; bus.Mem_LB = 1'b0;
  endtask

  task automatic wr_burst(input logic [15:0] a, input logic [15:0] d,
                          input logic ub, input logic lb, input int n);
    bus.ADDR = a; bus.Data_to_SRAM = d; bus.Mem_UB = ub; bus.Mem_LB = lb;
    bus.Mem_CE = 1'b0; bus.Mem_OE = 1'b1; bus.Mem_WE = 1'b0;
    repeat (n) tick;
    idle_bus;
    tick; tick;
  endtask

  // Two-cycle read; d/v sampled in the second OE-low cycle
  task automatic rd2(input logic [15:0] a, input logic ub, input logic lb,
                     output logic [15:0] d, output logic v);
    bus.ADDR = a; bus.Mem_UB = ub; bus.Mem_LB = lb;
    bus.Mem_CE = 1'b0; bus.Mem_OE = 1'b0; bus.Mem_WE = 1'b1;
    tick;
    d = bus.Data_from_SRAM; v = bus.Rd_Valid;
    tick;
    idle_bus;
    tick;
  endtask

  logic [15:0] d;
  logic        v;
  int          a0, v0;

  initial begin
    Reset = 1'b0; Switches = 16'h0000;
    bus.ADDR = '0; bus.Data_to_SRAM = '0;
    idle_bus;
    #2;
    chk("rst_data",  bus.Data_from_SRAM, 16'h0000);
    chk("rst_valid", bus.Rd_Valid, 1'b0);
    chk("rst_ack",   bus.Wr_Ack, 1'b0);
    chk("rst_hex",   HEX_Data, 16'h0000);
    tick; tick;
    Reset = 1'b1;
    tick;

    // Write then read, with Wr_Ack timing
    a0 = ack_cnt;
    bus.ADDR = 16'h0010; bus.Data_to_SRAM = 16'hBEEF;
    bus.Mem_CE = 1'b0; bus.Mem_WE = 1'b0;
    tick;
    chk("ack_early", bus.Wr_Ack, 1'b0);
    tick;
    idle_bus;
    chk("ack_pulse", bus.Wr_Ack, 1'b1);
    tick; tick;
    chk("ack_once", ack_cnt - a0, 1);
    rd2(16'h0010, 1'b0, 1'b0, d, v);
    chk("rd_beef", d, 16'hBEEF);
    chk("rd_beef_vld", v, 1'b1);

    // Byte lanes
    wr_burst(16'h0020, 16'h1234, 1'b0, 1'b0, 2);
    wr_burst(16'h0020, 16'hABCD, 1'b1, 1'b0, 2);
    rd2(16'h0020, 1'b0, 1'b0, d, v);
    chk("lane_lo_wr", d, 16'h12CD);
    rd2(16'h0020, 1'b0, 1'b1, d, v);
    chk("lane_hi_rd", d, 16'h1200);
    a0 = ack_cnt;
    wr_burst(16'h0020, 16'hFFFF, 1'b1, 1'b1, 2);
    chk("lane_none_ack", ack_cnt - a0, 1);
    rd2(16'h0020, 1'b0, 1'b0, d, v);
    chk("lane_none_data", d, 16'h12CD);

    // Memory-mapped I/O
    wr_burst(16'h0FFF, 16'h7777, 1'b0, 1'b0, 2);
    Switches = 16'h5A5A;
    rd2(16'hFFFF, 1'b0, 1'b0, d, v);
    chk("io_rd", d, 16'h5A5A);
    wr_burst(16'hFFFF, 16'h00C3, 1'b0, 1'b0, 2);
    chk("io_hex", HEX_Data, 16'h00C3);
    rd2(16'h0FFF, 1'b0, 1'b0, d, v);
    chk("io_ram_untouched", d, 16'h7777);

    // One-cycle strobes have no effect
    wr_burst(16'h0030, 16'h0000, 1'b0, 1'b0, 2);
    a0 = ack_cnt;
    wr_burst(16'h0030, 16'hDEAD, 1'b0, 1'b0, 1);
    chk("abort_wr_ack", ack_cnt - a0, 0);
    v0 = vld_cnt;
    bus.ADDR = 16'h0030; bus.Mem_CE = 1'b0; bus.Mem_OE = 1'b0;
    tick;
    idle_bus;
    tick; tick;
    chk("abort_rd_vld", vld_cnt - v0, 0);
    rd2(16'h0030, 1'b0, 1'b0, d, v);
    chk("abort_wr_data", d, 16'h0000);

    // WE held 5 cycles, data changing each cycle
    a0 = ack_cnt;
    bus.ADDR = 16'h0040; bus.Mem_CE = 1'b0; bus.Mem_WE = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      bus.Data_to_SRAM = 16'(i);
      tick;
    end
    idle_bus;
    tick; tick;
    chk("held_wr_ack", ack_cnt - a0, 1);
    rd2(16'h0040, 1'b0, 1'b0, d, v);
    chk("held_wr_data", d, 16'h0002);

    // OE held 4 cycles, address changes in cycle 3
    wr_burst(16'h0050, 16'h1111, 1'b0, 1'b0, 2);
    wr_burst(16'h0051, 16'h2222, 1'b0, 1'b0, 2);
    bus.ADDR = 16'h0050; bus.Mem_CE = 1'b0; bus.Mem_OE = 1'b0;
    tick;
    chk("held_rd_c2", bus.Data_from_SRAM, 16'h1111);
    tick;
    bus.ADDR = 16'h0051;
    chk("held_rd_c3", bus.Data_from_SRAM, 16'h1111);
    tick;
    chk("held_rd_c4", bus.Data_from_SRAM, 16'h2222);
    chk("held_rd_vld", bus.Rd_Valid, 1'b1);
    idle_bus;
    tick; tick;

    // Reset asserted while in WR1
    wr_burst(16'h0060, 16'h0000, 1'b0, 1'b0, 2);
    a0 = ack_cnt;
    bus.ADDR = 16'h0060; bus.Data_to_SRAM = 16'h9999;
    bus.Mem_CE = 1'b0; bus.Mem_WE = 1'b0;
    tick;
    #2 Reset = 1'b0;
    #1;
    chk("rst_mid_hex", HEX_Data, 16'h0000);
    chk("rst_mid_ack", bus.Wr_Ack, 1'b0);
    tick;
    idle_bus;
    Reset = 1'b1;
    tick; tick;
    chk("rst_mid_noack", ack_cnt - a0, 0);
    rd2(16'h0060, 1'b0, 1'b0, d, v);
    chk("rst_mid_nocommit", d, 16'h0000);

    // OE and WE both low: a write
    a0 = ack_cnt; v0 = vld_cnt;
    bus.ADDR = 16'h0070; bus.Data_to_SRAM = 16'h4242;
    bus.Mem_CE = 1'b0; bus.Mem_OE = 1'b0; bus.Mem_WE = 1'b0;
    tick; tick;
    idle_bus;
    tick; tick;
    chk("conflict_vld", vld_cnt - v0, 0);
    chk("conflict_ack", ack_cnt - a0, 1);
    rd2(16'h0070, 1'b0, 1'b0, d, v);
    chk("conflict_data", d, 16'h4242);

    // Out of range: dropped write (no alias onto word 0), reads as zero
    wr_burst(16'h0000, 16'h1357, 1'b0, 1'b0, 2);
    a0 = ack_cnt;
    wr_burst(16'h2000, 16'hBAD1, 1'b0, 1'b0, 2);
    chk("oor_wr_ack", ack_cnt - a0, 1);
    rd2(16'h2000, 1'b0, 1'b0, d, v);
    chk("oor_rd_data", d, 16'h0000);
    chk("oor_rd_vld", v, 1'b1);
    rd2(16'h0000, 1'b0, 1'b0, d, v);
    chk("oor_no_alias", d, 16'h1357);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
